// File: rtl/demux_pkg.sv
// Shared constants and lane-state encoding for the 1-to-4 buffered demux.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package demux_pkg;

    localparam int SEL_W         = 2;
    localparam int NUM_LANES     = 4;
    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

endpackage

// File: rtl/demux_slot.sv
// One demux lane: single-entry word buffer, EMPTY/FULL state and delivered-word counter.
// Latency: a word written at edge N is visible with full=1 after edge N.
// Backpressure: holds its word while rd_rdy=0; a write alongside a read overwrites the slot.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   wr_en, wr_data  accept into this lane (already qualified by in_valid/in_ready/sel)
//   rd_rdy          lane consumer takes the word
//   full            lane holds a word (drives out_valid[k])
//   data            registered buffered word
//   cnt             delivered-word count, wraps modulo 2^CNT_W
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_rdy,
    output logic             full,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt
);

    lane_state_t state_q;
    lane_state_t state_d;
    logic        deliver;

    assign full    = (state_q == LANE_FULL);
    assign deliver = full && rd_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LANE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A write always leaves the lane FULL, even when the old word leaves
    // on the same edge; only a read without a write empties it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LANE_EMPTY: if (wr_en)   state_d = LANE_FULL;
            LANE_FULL:  if (deliver && !wr_en) state_d = LANE_EMPTY;
            default:    state_d = LANE_EMPTY;
        endcase
    end

    // Data only moves on a write, so it is stable for the whole FULL period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
            cnt  <= '0;
        end else begin
            if (wr_en) begin
                data <= wr_data;
            end
            if (deliver) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_1to4_buf.sv
// Routes one input word stream to one of four single-entry buffered output lanes by in_sel.
// Latency: one cycle from accept to out_valid on the selected lane.
// Backpressure: in_ready is low only when the selected lane is FULL and its consumer is not ready.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid/in_ready/in_sel/in_data   input handshake, lane select and word
//   out_valid[3:0]/out_ready[3:0]      per-lane output handshake
//   out_data0..3                  buffered words of lanes 0..3
//   out_cnt0..3                   delivered-word counters of lanes 0..3
module demux_1to4_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1,
    output logic [WIDTH-1:0]     out_data2,
    output logic [WIDTH-1:0]     out_data3,
    output logic [CNT_W-1:0]     out_cnt0,
    output logic [CNT_W-1:0]     out_cnt1,
    output logic [CNT_W-1:0]     out_cnt2,
    output logic [CNT_W-1:0]     out_cnt3
);

    logic [NUM_LANES-1:0] lane_full;
    logic [NUM_LANES-1:0] lane_wr;
    logic                 accept;
    logic [WIDTH-1:0]     lane_data [NUM_LANES];
    logic [CNT_W-1:0]     lane_cnt  [NUM_LANES];

    // Selected lane can take a word if empty, or if it drains on this same edge.
    assign in_ready = !lane_full[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lane_wr[k] = accept && (in_sel == SEL_W'(k));

        demux_slot #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (lane_wr[k]),
            .wr_data (in_data),
            .rd_rdy  (out_ready[k]),
            .full    (lane_full[k]),
            .data    (lane_data[k]),
            .cnt     (lane_cnt[k])
        );
    end

    assign out_valid = lane_full;
    assign out_data0 = lane_data[0];
    assign out_data1 = lane_data[1];
    assign out_data2 = lane_data[2];
    assign out_data3 = lane_data[3];
    assign out_cnt0  = lane_cnt[0];
    assign out_cnt1  = lane_cnt[1];
    assign out_cnt2  = lane_cnt[2];
    assign out_cnt3  = lane_cnt[3];

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Directed self-checking bench for demux_1to4_buf.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected values are hand-computed constants.
module tb_demux_1to4_buf;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [31:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
    logic [7:0]  out_cnt0, out_cnt1, out_cnt2, out_cnt3;

    int checks = 0;
    int errors = 0;

    demux_1to4_buf #(.WIDTH(32), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_cnt0  (out_cnt0),
        .out_cnt1  (out_cnt1),
        .out_cnt2  (out_cnt2),
        .out_cnt3  (out_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 32'h0;
        out_ready = 4'b0000;
        @(negedge clk);

        // Reset for two cycles
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_data0", 64'(out_data0), 64'h0);
        check("rst_data2", 64'(out_data2), 64'h0);
        check("rst_cnt0",  64'(out_cnt0),  64'h0);
        check("rst_cnt3",  64'(out_cnt3),  64'h0);
        rst_n = 1'b1;

        // Single accept into lane 2
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 32'hDEADBEEF;
        #1;
        check("acc_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        check("acc_valid", 64'(out_valid), 64'h4);
        check("acc_data2", 64'(out_data2), 64'hDEADBEEF);
        check("acc_data0", 64'(out_data0), 64'h0);
        check("acc_data1", 64'(out_data1), 64'h0);
        check("acc_data3", 64'(out_data3), 64'h0);

        // Backpressure on lane 1, then redirect to lane 3
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 32'hAAAA5555;
        tick();
        check("bp_fill_valid", 64'(out_valid), 64'h6);
        in_data = 32'h11111111;
        #1;
        check("bp_ready_lo", 64'(in_ready), 64'h0);
        tick();
        check("bp_data1_held", 64'(out_data1), 64'hAAAA5555);
        check("bp_valid_held", 64'(out_valid), 64'h6);
        in_sel = 2'd3;
        #1;
        check("bp_ready_hi", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        check("bp_data3", 64'(out_data3), 64'h11111111);
        check("bp_valid3", 64'(out_valid), 64'hE);

        // Idle input: sel/data ignored
        in_sel  = 2'd0;
        in_data = 32'hFFFFFFFF;
        tick();
        check("idle_valid", 64'(out_valid), 64'hE);
        check("idle_data0", 64'(out_data0), 64'h0);

        // Full-rate pass-through on lane 0: preload word 0, then stream 1..10
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 32'd0;
        tick();
        out_ready = 4'b0001;
        for (int i = 1; i <= 10; i++) begin
            in_data = 32'(i);
            #1;
            check("pt_ready", 64'(in_ready), 64'h1);
            check("pt_order", 64'(out_data0), 64'(i - 1));
            tick();
        end
        check("pt_cnt0_10", 64'(out_cnt0), 64'd10);
        check("pt_last", 64'(out_data0), 64'd10);
        in_valid = 1'b0;
        tick();
        out_ready = 4'b0000;
        check("pt_cnt0_11", 64'(out_cnt0), 64'd11);
        check("pt_valid", 64'(out_valid), 64'hE);

        // Parallel drain of all four lanes
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 32'h55;
        tick();
        in_valid = 1'b0;
        check("pd_full", 64'(out_valid), 64'hF);
        out_ready = 4'b1111;
        tick();
        out_ready = 4'b0000;
        check("pd_valid", 64'(out_valid), 64'h0);
        check("pd_cnt0", 64'(out_cnt0), 64'd12);
        check("pd_cnt1", 64'(out_cnt1), 64'd1);
        check("pd_cnt2", 64'(out_cnt2), 64'd1);
        check("pd_cnt3", 64'(out_cnt3), 64'd1);
        check("pd_data2_held", 64'(out_data2), 64'hDEADBEEF);

        // Lane 2 counter wrap: cnt2 starts at 1, 255 deliveries -> 0, one more -> 1
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 32'h2;
        tick();
        out_ready = 4'b0100;
        for (int i = 0; i < 255; i++) begin
            tick();
        end
        check("wrap_cnt2_0", 64'(out_cnt2), 64'd0);
        tick();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        check("wrap_cnt2_1", 64'(out_cnt2), 64'd1);
        check("wrap_cnt0", 64'(out_cnt0), 64'd12);
        check("wrap_cnt1", 64'(out_cnt1), 64'd1);
        check("wrap_cnt3", 64'(out_cnt3), 64'd1);
        check("wrap_valid", 64'(out_valid), 64'h4);

        // Reset mid-operation with lanes 0, 2, 3 full and consumers ready
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 32'hA0;
        tick();
        in_sel  = 2'd3;
        in_data = 32'hA3;
        tick();
        in_valid = 1'b0;
        check("mr_pre_valid", 64'(out_valid), 64'hD);
        rst_n     = 1'b0;
        out_ready = 4'b1111;
        tick();
        rst_n     = 1'b1;
        out_ready = 4'b0000;
        check("mr_valid", 64'(out_valid), 64'h0);
        check("mr_data0", 64'(out_data0), 64'h0);
        check("mr_data2", 64'(out_data2), 64'h0);
        check("mr_data3", 64'(out_data3), 64'h0);
        check("mr_cnt0", 64'(out_cnt0), 64'h0);
        check("mr_cnt1", 64'(out_cnt1), 64'h0);
        check("mr_cnt2", 64'(out_cnt2), 64'h0);
        check("mr_cnt3", 64'(out_cnt3), 64'h0);

        // Normal operation resumes after reset
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 32'h12345678;
        tick();
        in_valid = 1'b0;
        check("post_valid", 64'(out_valid), 64'h2);
        check("post_data1", 64'(out_data1), 64'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
